// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and helpers for the branch redirect controller.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } br_ctrl_state_t;

  // The drain counter must hold FLUSH_BUBBLES; never narrower than one bit.
  function automatic int drain_cnt_width(input int bubbles);
    return (bubbles < 1) ? 1 : $clog2(bubbles + 1);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Bundle between the EX-stage branch unit, the redirect controller and IF-stage PC logic.
interface branch_redirect_ctrl_if #(
  parameter int PC_W = 32
);
  logic            ex_valid;
  logic            ex_jump_en;
  logic [PC_W-1:0] ex_jump_target;
  logic            ex_stall;
  logic            if_ready;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush_if;
  logic            flush_id;
  logic            ex_kill;
  logic            if_drop;
  logic            ale_excp;
  logic [PC_W-1:0] ale_badv;

  modport master (
    input  ex_valid, ex_jump_en, ex_jump_target, ex_stall, if_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id, ex_kill, if_drop,
           ale_excp, ale_badv
  );

  modport slave (
    output ex_valid, ex_jump_en, ex_jump_target, ex_stall, if_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id, ex_kill, if_drop,
           ale_excp, ale_badv
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: flush, hold target until fetch accepts, then drain stale responses.
// Optional macro BR_ALIGN_CHECK_EN turns misaligned targets into an exception instead of a redirect.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_BUBBLES = 2,
  parameter int PC_W          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_redirect_ctrl_if.master bus
);

  localparam int CNT_W = drain_cnt_width(FLUSH_BUBBLES);

  br_ctrl_state_t  state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q;
  logic [PC_W-1:0]  redirect_pc_q;
  logic             kill;
  logic             accept;
  logic             misaligned;
  logic             take_redirect;

  // Only REDIR kills EX, so accept never sees a killed slot combinationally looping back.
  assign kill   = (state_q == REDIR);
  assign accept = bus.ex_valid & bus.ex_jump_en & ~bus.ex_stall & ~kill;

`ifdef BR_ALIGN_CHECK_EN
  assign misaligned = accept & (bus.ex_jump_target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign take_redirect = accept & ~misaligned;

  // NOTE: every output is defaulted before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d            = state_q;
    bus.flush_if       = 1'b0;
    bus.flush_id       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.if_drop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bus.flush_if = 1'b1;
          bus.flush_id = 1'b1;
          if (take_redirect) state_d = REDIR;
        end
      end
      REDIR: begin
        bus.redirect_valid = 1'b1;
        bus.flush_if       = 1'b1;
        if (bus.if_ready) state_d = (FLUSH_BUBBLES == 0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        bus.if_drop = 1'b1;
        // A new taken branch preempts the remaining drain cycles.
        if (accept) begin
          bus.flush_if = 1'b1;
          bus.flush_id = 1'b1;
          state_d      = take_redirect ? REDIR : IDLE;
        end else if (drain_cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      drain_cnt_q   <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_redirect) redirect_pc_q <= bus.ex_jump_target;
      if (state_q == REDIR && bus.if_ready) begin
        drain_cnt_q <= CNT_W'(FLUSH_BUBBLES);
      end else if (state_q == DRAIN && drain_cnt_q != '0) begin
        drain_cnt_q <= drain_cnt_q - 1'b1;
      end
    end
  end

  assign bus.ex_kill     = kill;
  assign bus.redirect_pc = redirect_pc_q;

`ifdef BR_ALIGN_CHECK_EN
  logic            ale_excp_q;
  logic [PC_W-1:0] ale_badv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ale_excp_q <= 1'b0;
      ale_badv_q <= '0;
    end else begin
      ale_excp_q <= misaligned;
      if (misaligned) ale_badv_q <= bus.ex_jump_target;
    end
  end

  assign bus.ale_excp = ale_excp_q;
  assign bus.ale_badv = ale_badv_q;
`else
  assign bus.ale_excp = 1'b0;
  assign bus.ale_badv = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_branch_redirect_ctrl;

  localparam int FB   = 2;
  localparam int PC_W = 32;
`ifdef BR_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.PC_W(PC_W)) bi ();

  branch_redirect_ctrl #(.FLUSH_BUBBLES(FB), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bi.master)
  );

  int errors = 0;
  int checks = 0;

  // Currently applied inputs
  bit          cur_v, cur_j, cur_s, cur_r, cur_rst;
  logic [31:0] cur_t;

  // Reference model: a pending redirect, a count of remaining drop cycles, a pending exception.
  bit          m_pend;
  logic [31:0] m_pc;
  int          m_drop;
  bit          m_excp;
  logic [31:0] m_badv;
  logic [5:0]  exp_outs;

  // Output order: flush_if, flush_id, redirect_valid, ex_kill, if_drop, ale_excp
  function automatic logic [5:0] outs();
    return {bi.flush_if, bi.flush_id, bi.redirect_valid, bi.ex_kill, bi.if_drop, bi.ale_excp};
  endfunction

  function automatic bit m_accept();
    return cur_v & cur_j & ~cur_s & ~m_pend;
  endfunction

  task automatic model_eval();
    bit acc;
    acc      = m_accept();
    exp_outs = {acc | m_pend, acc, m_pend, m_pend, (m_drop > 0), m_excp};
  endtask

  task automatic model_update();
    bit acc;
    acc = m_accept();
    if (cur_rst) begin
      m_pend = 0; m_pc = '0; m_drop = 0; m_excp = 0; m_badv = '0;
    end else begin
      m_excp = 0;
      if (m_pend) begin
        if (cur_r) begin
          m_pend = 0;
          m_drop = FB;
        end
      end else if (acc) begin
        m_drop = 0;
        if (ALIGN && cur_t[1:0] != 2'b00) begin
          m_excp = 1;
          m_badv = cur_t;
        end else begin
          m_pend = 1;
          m_pc   = cur_t;
        end
      end else if (m_drop > 0) begin
        m_drop--;
      end
    end
  endtask

  // One clock: commit the previous inputs into the model, apply new ones, stop at the negedge.
  task automatic apply(input bit v, input bit j, input logic [31:0] t,
                       input bit s, input bit r, input bit rs);
    @(posedge clk);
    model_update();
    #1;
    cur_v = v; cur_j = j; cur_t = t; cur_s = s; cur_r = r; cur_rst = rs;
    bi.ex_valid = v; bi.ex_jump_en = j; bi.ex_jump_target = t;
    bi.ex_stall = s; bi.if_ready = r; rst = rs;
    model_eval();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    apply(0, 0, '0, 0, 0, 1);
    apply(0, 0, '0, 0, 0, 1);
    apply(0, 0, '0, 0, 0, 0);
    checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs(), 6'b000000); end
    checks++; if (bi.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bi.redirect_pc, 32'h0); end
    checks++; if (bi.ale_badv !== 32'h0) begin errors++; $display("FAIL reset_badv got=%h exp=%h", bi.ale_badv, 32'h0); end
  endtask

  // Accept at T, handshake at T+1, drop for FB cycles, idle afterwards.
  task automatic test_basic(input string tag);
    apply(1, 1, 32'h1C000040, 0, 0, 0);
    checks++; if (outs() !== 6'b110000) begin errors++; $display("FAIL %s_T got=%b exp=%b", tag, outs(), 6'b110000); end
    apply(0, 0, '0, 0, 1, 0);
    checks++; if (outs() !== 6'b101100) begin errors++; $display("FAIL %s_T1 got=%b exp=%b", tag, outs(), 6'b101100); end
    checks++; if (bi.redirect_pc !== 32'h1C000040) begin errors++; $display("FAIL %s_pc got=%h exp=%h", tag, bi.redirect_pc, 32'h1C000040); end
    for (int i = 0; i < FB; i++) begin
      apply(0, 0, '0, 0, 0, 0);
      checks++; if (outs() !== 6'b000010) begin errors++; $display("FAIL %s_drain%0d got=%b exp=%b", tag, i, outs(), 6'b000010); end
    end
    apply(0, 0, '0, 0, 0, 0);
    checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL %s_idle got=%b exp=%b", tag, outs(), 6'b000000); end
  endtask

  task automatic test_backpressure();
    apply(1, 1, 32'h1C000040, 0, 0, 0);
    checks++; if (outs() !== 6'b110000) begin errors++; $display("FAIL bp_T got=%b exp=%b", outs(), 6'b110000); end
    for (int i = 0; i < 4; i++) begin
      // EX inputs wiggle while the redirect waits; they must be ignored.
      apply(1, 1, 32'hDEAD0000, 0, (i == 3), 0);
      checks++; if (outs() !== 6'b101100) begin errors++; $display("FAIL bp_wait%0d got=%b exp=%b", i, outs(), 6'b101100); end
      checks++; if (bi.redirect_pc !== 32'h1C000040) begin errors++; $display("FAIL bp_pc%0d got=%h exp=%h", i, bi.redirect_pc, 32'h1C000040); end
    end
    idle(FB + 1);
    checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL bp_idle got=%b exp=%b", outs(), 6'b000000); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 32'h1C000040, 1, 0, 0);
      checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL stall%0d got=%b exp=%b", i, outs(), 6'b000000); end
    end
    test_basic("stall_rel");
  endtask

  task automatic test_not_taken();
    for (int i = 0; i < 10; i++) begin
      apply(1, 0, 32'h1C000080 + 32'(i * 4), 0, 1, 0);
      checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL not_taken%0d got=%b exp=%b", i, outs(), 6'b000000); end
    end
  endtask

  task automatic test_misaligned();
    apply(1, 1, 32'h1C000042, 0, 0, 0);
    checks++; if (outs() !== 6'b110000) begin errors++; $display("FAIL mis_T got=%b exp=%b", outs(), 6'b110000); end
    apply(0, 0, '0, 0, 1, 0);
    if (ALIGN) begin
      checks++; if (outs() !== 6'b000001) begin errors++; $display("FAIL mis_excp got=%b exp=%b", outs(), 6'b000001); end
      checks++; if (bi.ale_badv !== 32'h1C000042) begin errors++; $display("FAIL mis_badv got=%h exp=%h", bi.ale_badv, 32'h1C000042); end
      apply(0, 0, '0, 0, 1, 0);
      checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL mis_after got=%b exp=%b", outs(), 6'b000000); end
    end else begin
      checks++; if (outs() !== 6'b101100) begin errors++; $display("FAIL mis_redir got=%b exp=%b", outs(), 6'b101100); end
      checks++; if (bi.redirect_pc !== 32'h1C000042) begin errors++; $display("FAIL mis_pc got=%h exp=%h", bi.redirect_pc, 32'h1C000042); end
    end
    idle(FB + 1);
  endtask

  task automatic test_reset_mid();
    apply(1, 1, 32'h1C000040, 0, 0, 0);
    apply(0, 0, '0, 0, 0, 1);            // reset sampled while in REDIR
    apply(0, 0, '0, 0, 0, 0);
    checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL rst_redir got=%b exp=%b", outs(), 6'b000000); end
    checks++; if (bi.redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redir_pc got=%h exp=%h", bi.redirect_pc, 32'h0); end
    test_basic("post_rst_redir");
    apply(1, 1, 32'h1C000040, 0, 0, 0);
    apply(0, 0, '0, 0, 1, 0);
    apply(0, 0, '0, 0, 0, 1);            // reset sampled in first DRAIN cycle
    apply(0, 0, '0, 0, 0, 0);
    checks++; if (outs() !== 6'b000000) begin errors++; $display("FAIL rst_drain got=%b exp=%b", outs(), 6'b000000); end
    test_basic("post_rst_drain");
  endtask

  task automatic test_drain_accept();
    apply(1, 1, 32'h1C000040, 0, 0, 0);
    apply(0, 0, '0, 0, 1, 0);
    apply(0, 0, '0, 0, 0, 0);
    apply(1, 1, 32'h1C000100, 0, 0, 0);  // second DRAIN cycle
    checks++; if (outs() !== 6'b110010) begin errors++; $display("FAIL drain_acc_T got=%b exp=%b", outs(), 6'b110010); end
    apply(0, 0, '0, 0, 1, 0);
    checks++; if (outs() !== 6'b101100) begin errors++; $display("FAIL drain_acc_redir got=%b exp=%b", outs(), 6'b101100); end
    checks++; if (bi.redirect_pc !== 32'h1C000100) begin errors++; $display("FAIL drain_acc_pc got=%h exp=%h", bi.redirect_pc, 32'h1C000100); end
    idle(FB + 1);
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      apply(($urandom_range(3) != 0), ($urandom_range(2) == 0), t,
            ($urandom_range(3) == 0), $urandom_range(1) == 1, ($urandom_range(80) == 0));
      checks++; if (outs() !== exp_outs) begin errors++; $display("FAIL rand_outs cyc=%0d got=%b exp=%b", i, outs(), exp_outs); end
      checks++; if (bi.redirect_pc !== m_pc) begin errors++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, bi.redirect_pc, m_pc); end
      checks++; if (bi.ale_badv !== m_badv) begin errors++; $display("FAIL rand_badv cyc=%0d got=%h exp=%h", i, bi.ale_badv, m_badv); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cur_rst = 1; cur_v = 0; cur_j = 0; cur_s = 0; cur_r = 0; cur_t = '0;
    bi.ex_valid = 0; bi.ex_jump_en = 0; bi.ex_jump_target = '0; bi.ex_stall = 0; bi.if_ready = 0;
    m_pend = 0; m_pc = '0; m_drop = 0; m_excp = 0; m_badv = '0; exp_outs = '0;
    test_reset();
    test_basic("basic");
    test_backpressure();
    test_stall();
    test_not_taken();
    test_misaligned();
    test_reset_mid();
    test_drain_accept();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
